// File: rtl/onehot_receiver.sv
// onehot_receiver: decodes a registered 4-wire one-hot symbol stream,
// reassembles WORD_BITS-wide words LSB symbol first, and presents them on
// a valid/ready output register. Illegal codes, mid-word stalls and
// overflow are flagged as one-cycle pulses and counted in err_cnt, which
// saturates at all-ones.
module onehot_receiver #(
  parameter int WORD_BITS = 32,
  parameter int GAP_MAX   = 15,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           in,
  output logic [WORD_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_code,
  output logic                 err_timeout,
  output logic                 err_ovf,
  output logic [CNT_BITS-1:0]  err_cnt
);

  localparam int SYMS  = WORD_BITS / 2;
  localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int GAP_W = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t               state, state_n;
  logic [3:0]           in_q;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [GAP_W-1:0]     gap, gap_n;
  logic [WORD_BITS-1:0] sh, sh_n;
  logic [WORD_BITS-1:0] word;
  logic [IDX_W:0]       bpos;
  logic                 load;
  logic                 e_code, e_to, e_ovf;
  logic                 legal, is_idle;
  logic [1:0]           sym;

  // Decode the registered line into idle / legal symbol / illegal.
  always_comb begin
    legal   = 1'b0;
    is_idle = 1'b0;
    sym     = 2'd0;
    case (in_q)
      4'b0000: is_idle = 1'b1;
      4'b0001: begin legal = 1'b1; sym = 2'd0; end
      4'b0010: begin legal = 1'b1; sym = 2'd1; end
      4'b0100: begin legal = 1'b1; sym = 2'd2; end
      4'b1000: begin legal = 1'b1; sym = 2'd3; end
      default: ;
    endcase
  end

  // Next-state: symbol placement, gap tracking, word completion and errors.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    gap_n   = gap;
    sh_n    = sh;
    word    = sh;
    load    = 1'b0;
    e_code  = 1'b0;
    e_to    = 1'b0;
    e_ovf   = 1'b0;
    bpos    = {idx, 1'b0};
    if (!legal && !is_idle) begin
      // A multi-hot code is never a symbol; it aborts any partial word.
      e_code  = 1'b1;
      idx_n   = '0;
      gap_n   = '0;
      sh_n    = '0;
      state_n = IDLE;
    end else if (legal) begin
      case (state)
        IDLE: begin
          sh_n        = '0;
          sh_n[1:0]   = sym;
          idx_n       = IDX_W'(1);
          gap_n       = '0;
          state_n     = RECV;
        end
        default: begin
          word           = sh;
          word[bpos +: 2] = sym;
          if (idx == LAST_IDX) begin
            // A word leaving this cycle frees the register for the new one.
            if (!out_valid || out_ready) load  = 1'b1;
            else                         e_ovf = 1'b1;
            idx_n   = '0;
            gap_n   = '0;
            sh_n    = '0;
            state_n = IDLE;
          end else begin
            sh_n  = word;
            idx_n = idx + IDX_W'(1);
            gap_n = '0;
          end
        end
      endcase
    end else if (state == RECV) begin
      // Idle mid-word: abort once the stall reaches GAP_MAX cycles.
      if (gap == GAP_LAST) begin
        e_to    = 1'b1;
        idx_n   = '0;
        gap_n   = '0;
        sh_n    = '0;
        state_n = IDLE;
      end else begin
        gap_n = gap + GAP_W'(1);
      end
    end
  end

  // Input register and assembly state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= '0;
      state <= IDLE;
      idx   <= '0;
      gap   <= '0;
      sh    <= '0;
    end else begin
      in_q  <= in;
      state <= state_n;
      idx   <= idx_n;
      gap   <= gap_n;
      sh    <= sh_n;
    end
  end

  // Output register with valid/ready hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error pulses and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_code    <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      err_cnt     <= '0;
    end else begin
      err_code    <= e_code;
      err_timeout <= e_to;
      err_ovf     <= e_ovf;
      if ((e_code || e_to || e_ovf) && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_onehot_receiver.sv
// Scoreboard bench for onehot_receiver: stimulus feeds a symbol-list model
// that queues expected words and error events; a monitor pops and compares
// whenever the DUT hands off a word or pulses an error.
module tb_onehot_receiver;
  localparam int WB   = 32;
  localparam int GAPM = 15;
  localparam int CB   = 8;
  localparam int SYMS = WB / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    in = '0;
  logic [WB-1:0] out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          err_code, err_timeout, err_ovf;
  logic [CB-1:0] err_cnt;

  onehot_receiver #(.WORD_BITS(WB), .GAP_MAX(GAPM), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .err_code(err_code), .err_timeout(err_timeout),
    .err_ovf(err_ovf), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Scoreboard queues.
  logic [WB-1:0] wq[$];
  logic [2:0]    etq[$];   // {code, timeout, ovf}
  int            ecq[$];

  // Model state: collected symbols of the partial word, stall length,
  // output-register occupancy, error count, code seen one cycle ago.
  int            m_n, m_gap, m_cnt;
  logic [WB-1:0] m_word;
  bit            m_full;
  logic [3:0]    pend;

  function automatic void chk(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void m_clear();
    m_n = 0; m_gap = 0; m_word = '0;
  endfunction

  function automatic void m_err(logic [2:0] t);
    if (m_cnt != 255) m_cnt++;
    etq.push_back(t);
    ecq.push_back(m_cnt);
    m_clear();
  endfunction

  // Behaviour of one decoded code c, seen while out_ready = rdy.
  function automatic void model(logic [3:0] c, bit rdy);
    bit consumed = m_full && rdy;
    bit done = 0;
    int s;
    if (c == 4'b0000) begin
      if (m_n > 0) begin
        m_gap++;
        if (m_gap == GAPM) m_err(3'b010);
      end
    end else if (c == 4'd1 || c == 4'd2 || c == 4'd4 || c == 4'd8) begin
      s = (c == 4'd1) ? 0 : (c == 4'd2) ? 1 : (c == 4'd4) ? 2 : 3;
      m_word = m_word + (WB'(s) << (2 * m_n));
      m_n++;
      m_gap = 0;
      if (m_n == SYMS) begin
        if (!m_full || rdy) begin
          wq.push_back(m_word);
          done = 1;
          m_clear();
        end else begin
          m_err(3'b001);
        end
      end
    end else begin
      m_err(3'b100);
    end
    if (done) m_full = 1;
    else if (consumed) m_full = 0;
  endfunction

  // One cycle: drive, let the model see the previously registered code.
  task automatic cyc(input logic [3:0] code, input bit rdy);
    in = code;
    out_ready = rdy;
    model(pend, rdy);
    pend = code;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] sym_code(logic [WB-1:0] w, int i);
    logic [WB-1:0] t;
    t = w >> (2 * i);
    return 4'b0001 << t[1:0];
  endfunction

  task automatic send_word(input logic [WB-1:0] w, input bit rdy);
    for (int i = 0; i < SYMS; i++) cyc(sym_code(w, i), rdy);
  endtask

  function automatic logic [3:0] bad_code();
    logic [3:0] c;
    do c = 4'($urandom_range(3, 15)); while (c == 4'd4 || c == 4'd8);
    return c;
  endfunction

  bit mon_prev_hold = 0;
  logic [WB-1:0] mon_prev_out;

  task automatic do_reset();
    rst = 1'b1; in = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_errs", {err_code, err_timeout, err_ovf}, 0);
    chk("rst_cnt", err_cnt, 0);
    wq.delete(); etq.delete(); ecq.delete();
    m_clear(); m_full = 0; m_cnt = 0; pend = '0; mon_prev_hold = 0;
    rst = 1'b0;
  endtask

  // Monitor: pop expectations on hand-offs and error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_hold = 0;
      end else begin
        if (mon_prev_hold && out_valid) chk("out_stable", out, mon_prev_out);
        if (out_valid && out_ready) begin
          if (wq.size() == 0) chk("word_extra", out, -1);
          else chk("word", out, wq.pop_front());
        end
        if (err_code || err_timeout || err_ovf) begin
          if (etq.size() == 0) chk("err_extra", {err_code, err_timeout, err_ovf}, 0);
          else begin
            chk("err_type", {err_code, err_timeout, err_ovf}, etq.pop_front());
            chk("err_cnt", err_cnt, ecq.pop_front());
          end
        end
        mon_prev_hold = out_valid && !out_ready;
        mon_prev_out  = out;
      end
    end
  end

  initial begin
    logic [WB-1:0] w;
    @(posedge clk); #1;
    do_reset();
    repeat (2) cyc(4'b0000, 1);

    // sym 1 then fifteen sym 0, three idles after symbol 5; check latency.
    cyc(4'b0010, 1);
    for (int i = 1; i < SYMS; i++) begin
      cyc(4'b0001, 1);
      if (i == 5) repeat (3) cyc(4'b0000, 1);
    end
    chk("lat_n1_valid", out_valid, 0);
    cyc(4'b0000, 1);
    chk("lat_n2_valid", out_valid, 1);
    chk("lat_n2_out", out, 32'h1);
    cyc(4'b0000, 1);
    chk("one_cycle_valid", out_valid, 0);
    chk("no_err_cnt", err_cnt, 0);

    // Illegal code mid-word, then a clean word.
    for (int i = 0; i < 5; i++) cyc(4'b0100, 1);
    cyc(4'b0110, 1);
    send_word(32'hDEADBEEF, 1);
    repeat (3) cyc(4'b0000, 1);
    chk("code_cnt", err_cnt, 1);

    // Stall timeout, then a 14-cycle stall that survives.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b1000, 1);
    repeat (GAPM) cyc(4'b0000, 1);
    repeat (3) cyc(4'b0000, 1);
    chk("to_cnt", err_cnt, 1);
    w = 32'hA5C3_96E1;
    for (int i = 0; i < 3; i++) cyc(sym_code(w, i), 1);
    repeat (GAPM - 1) cyc(4'b0000, 1);
    for (int i = 3; i < SYMS; i++) cyc(sym_code(w, i), 1);
    repeat (3) cyc(4'b0000, 1);
    chk("gap14_cnt", err_cnt, 1);

    // Overflow with the consumer stalled, then a just-in-time accept.
    do_reset();
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    repeat (3) cyc(4'b0000, 0);
    chk("ovf_hold", out, 32'h11111111);
    chk("ovf_cnt", err_cnt, 1);
    for (int i = 0; i < SYMS; i++) cyc(sym_code(32'h33333333, i), 0);
    cyc(4'b0000, 1);
    chk("jit_valid", out_valid, 1);
    chk("jit_out", out, 32'h33333333);
    repeat (2) cyc(4'b0000, 1);
    chk("jit_cnt", err_cnt, 1);

    // Randomized traffic: stalls, occasional illegal codes, random ready.
    for (int n = 0; n < 150; n++) begin
      w = WB'($urandom);
      for (int i = 0; i < SYMS; i++) begin
        if ($urandom_range(0, 9) == 0)
          repeat ($urandom_range(1, GAPM + 1)) cyc(4'b0000, $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 59) == 0) cyc(bad_code(), $urandom_range(0, 3) != 0);
        cyc(sym_code(w, i), $urandom_range(0, 3) != 0);
      end
    end
    repeat (4) cyc(4'b0000, 1);

    // Saturate the error counter.
    repeat (260) cyc(bad_code(), 1);
    repeat (3) cyc(4'b0000, 1);
    chk("sat_cnt", err_cnt, 255);

    // Reset mid-word with a held output word.
    send_word(32'hCAFEF00D, 0);
    for (int i = 0; i < 5; i++) cyc(4'b0001, 0);
    do_reset();

    // Drain and confirm nothing expected was left unseen.
    repeat (40) cyc(4'b0000, 1);
    chk("drain_words", wq.size(), 0);
    chk("drain_errs", etq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
